id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: none; data width fixed at 16 bits, register address 4 bits, 16 registers, R0 hardwired zero.
REQ-002 Clock  in  1  rising-edge clock, the single clock of the block.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Flush  in  1  branch/jump taken; kill the instruction in ID.
REQ-005 ID_Valid  in  1  ID holds a real instruction.
REQ-006 ID_RAddr1, ID_RAddr2, ID_WAddr  in  4 each  source/destination register numbers.
REQ-007 ID_UsesR2  in  1  instruction reads ID_RAddr2.
REQ-008 ID_RData1, ID_RData2, ID_Imm  in  16 each  register-file read data (already write-through bypassed), immediate.
REQ-009 ID_ALUOp  in  4;  ID_MemRead, ID_MemWrite, ID_RegWrite  in  1 each  decoded control.
REQ-010 MEM_WAddr  in  4;  MEM_RegWrite  in  1;  MEM_Result  in  16  EX/MEM-stage destination and value.
REQ-011 Stall  out  1  hold PC and IF/ID this cycle (combinational).
REQ-012 EX_Valid, EX_MemRead, EX_MemWrite, EX_RegWrite  out  1 each;  EX_ALUOp  out  4;  EX_WAddr, EX_RAddr1, EX_RAddr2  out  4 each.
REQ-013 EX_OpA, EX_OpB, EX_Imm  out  16 each  EX-stage operands.
REQ-014 StallCount  out  16  saturating count of stall cycles since reset.

Function
REQ-015 Pipeline register SHALL capture all ID_* fields on every rising edge unless bubble or reset applies; latency ID->EX exactly 1 cycle.
REQ-016 Load-use hazard SHALL be: EX_Valid & EX_MemRead & EX_RegWrite & EX_WAddr!=0 & ID_Valid & (EX_WAddr==ID_RAddr1 | (ID_UsesR2 & EX_WAddr==ID_RAddr2)).
REQ-017 Stall SHALL equal (hazard per REQ-016 or REQ-031) & ~Flush.
REQ-018 Bubble: when Stall=1 or Flush=1, next edge SHALL load EX_Valid, EX_MemRead, EX_MemWrite, EX_RegWrite =0, EX_WAddr=0; data fields don't-care but loaded from ID.
REQ-019 Flush SHALL take priority over Stall; Flush with hazard yields bubble and Stall=0.
REQ-020 Stall SHALL never last more than 1 cycle per load-use pair (bubble clears EX_MemRead).
REQ-021 ID_Valid=0 SHALL be treated as a bubble and never raise Stall.
REQ-022 Register 0 SHALL never be a hazard or forwarding source.
REQ-023 StallCount SHALL increment by 1 on each edge where Stall=1, saturating at 16'hFFFF.
REQ-024 EX_Imm SHALL pass unchanged from the registered immediate.

Reset
REQ-025 On Reset=1 at an edge, all EX_* outputs SHALL be 0 and StallCount SHALL be 0; reset overrides Flush and Stall.
REQ-026 Stall SHALL be 0 during the first cycle after reset (EX empty).
REQ-027 Reset mid-stall SHALL discard the stalled instruction; no pending state survives.

Configuration
REQ-028 Macro FWD_EN SHALL compile forwarding from EX/MEM into EX operands.
REQ-029 With FWD_EN: EX_OpA = MEM_Result when MEM_RegWrite & MEM_WAddr!=0 & MEM_WAddr==EX_RAddr1, else registered RData1; EX_OpB likewise with EX_RAddr2.
REQ-030 With FWD_EN, only REQ-016 hazards stall.
REQ-031 Without FWD_EN: EX_OpA/EX_OpB = registered RData1/RData2; Stall additionally asserts when ID_Valid & ID source (RAddr1, or RAddr2 if UsesR2) matches nonzero EX_WAddr with EX_Valid & EX_RegWrite, or matches nonzero MEM_WAddr with MEM_RegWrite; MEM_* inputs used only for compare.

Verification
REQ-032 Reset then ID add R3<-R1+R2 (RData1=5, RData2=7) -> next cycle EX_Valid=1, EX_WAddr=3, EX_OpA=5, EX_OpB=7, Stall=0.
REQ-033 EX holds load R4 (MemRead=1), ID reads R4 -> Stall=1 one cycle, EX_Valid=0 next, StallCount=1, then instruction enters EX.
REQ-034 Same as REQ-033 with Flush=1 -> Stall=0, bubble loaded, StallCount unchanged.
REQ-035 FWD_EN: MEM_WAddr=3, MEM_RegWrite=1, MEM_Result=16'h00AA, EX_RAddr1=3 -> EX_OpA=16'h00AA; with MEM_WAddr=0 -> EX_OpA=registered RData1.
REQ-036 No FWD_EN: EX writes R5, ID reads R5 (non-load) -> Stall=1 until producer leaves MEM (2 cycles), StallCount=2.
REQ-037 Force 65536 consecutive stalls -> StallCount holds 16'hFFFF; Reset -> 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall counter and optional
// EX/MEM operand forwarding (define FWD_EN to enable; default build stalls on RAW instead).
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic [3:0]  id_raddr1_i,
  input  logic [3:0]  id_raddr2_i,
  input  logic [3:0]  id_waddr_i,
  input  logic        id_uses_r2_i,
  input  logic [15:0] id_rdata1_i,
  input  logic [15:0] id_rdata2_i,
  input  logic [15:0] id_imm_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        id_reg_write_i,
  input  logic [3:0]  mem_waddr_i,
  input  logic        mem_reg_write_i,
  input  logic [15:0] mem_result_i,
  output logic        stall_o,
  output logic        ex_valid_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_reg_write_o,
  output logic [3:0]  ex_alu_op_o,
  output logic [3:0]  ex_waddr_o,
  output logic [3:0]  ex_raddr1_o,
  output logic [3:0]  ex_raddr2_o,
  output logic [15:0] ex_op_a_o,
  output logic [15:0] ex_op_b_o,
  output logic [15:0] ex_imm_o,
  output logic [15:0] stall_count_o
);

  logic        ex_valid_q, ex_valid_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic        ex_mem_write_q, ex_mem_write_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic [3:0]  ex_alu_op_q, ex_alu_op_d;
  logic [3:0]  ex_waddr_q, ex_waddr_d;
  logic [3:0]  ex_raddr1_q, ex_raddr1_d;
  logic [3:0]  ex_raddr2_q, ex_raddr2_d;
  logic [15:0] ex_rdata1_q, ex_rdata1_d;
  logic [15:0] ex_rdata2_q, ex_rdata2_d;
  logic [15:0] ex_imm_q, ex_imm_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        load_use_hz;
  logic        raw_hz;
  logic        bubble;

  // Does the instruction in ID read nonzero register waddr?
  function automatic logic id_reads(input logic [3:0] waddr);
    return (waddr != 4'd0) &&
           ((waddr == id_raddr1_i) || (id_uses_r2_i && (waddr == id_raddr2_i)));
  endfunction

  always_comb begin
    load_use_hz = ex_valid_q && ex_mem_read_q && ex_reg_write_q &&
                  id_valid_i && id_reads(ex_waddr_q);
  end

`ifdef FWD_EN
  logic fwd_a, fwd_b;

  always_comb begin
    raw_hz = 1'b0;
    fwd_a  = mem_reg_write_i && (mem_waddr_i != 4'd0) && (mem_waddr_i == ex_raddr1_q);
    fwd_b  = mem_reg_write_i && (mem_waddr_i != 4'd0) && (mem_waddr_i == ex_raddr2_q);
  end

  assign ex_op_a_o = fwd_a ? mem_result_i : ex_rdata1_q;
  assign ex_op_b_o = fwd_b ? mem_result_i : ex_rdata2_q;
`else
  // Without forwarding the result value is never consumed, only its destination.
  logic unused_mem_result;
  assign unused_mem_result = ^mem_result_i;

  always_comb begin
    raw_hz = id_valid_i &&
             ((ex_valid_q && ex_reg_write_q && id_reads(ex_waddr_q)) ||
              (mem_reg_write_i && id_reads(mem_waddr_i)));
  end

  assign ex_op_a_o = ex_rdata1_q;
  assign ex_op_b_o = ex_rdata2_q;
`endif

  assign stall_o = (load_use_hz || raw_hz) && !flush_i;
  assign bubble  = stall_o || flush_i || !id_valid_i;

  always_comb begin
    ex_valid_d     = !bubble;
    ex_mem_read_d  = !bubble && id_mem_read_i;
    ex_mem_write_d = !bubble && id_mem_write_i;
    ex_reg_write_d = !bubble && id_reg_write_i;
    ex_waddr_d     = bubble ? 4'd0 : id_waddr_i;
    ex_alu_op_d    = id_alu_op_i;
    ex_raddr1_d    = id_raddr1_i;
    ex_raddr2_d    = id_raddr2_i;
    ex_rdata1_d    = id_rdata1_i;
    ex_rdata2_d    = id_rdata2_i;
    ex_imm_d       = id_imm_i;
    stall_cnt_d    = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_alu_op_q    <= 4'd0;
      ex_waddr_q     <= 4'd0;
      ex_raddr1_q    <= 4'd0;
      ex_raddr2_q    <= 4'd0;
      ex_rdata1_q    <= 16'd0;
      ex_rdata2_q    <= 16'd0;
      ex_imm_q       <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_waddr_q     <= ex_waddr_d;
      ex_raddr1_q    <= ex_raddr1_d;
      ex_raddr2_q    <= ex_raddr2_d;
      ex_rdata1_q    <= ex_rdata1_d;
      ex_rdata2_q    <= ex_rdata2_d;
      ex_imm_q       <= ex_imm_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_mem_read_o  = ex_mem_read_q;
  assign ex_mem_write_o = ex_mem_write_q;
  assign ex_reg_write_o = ex_reg_write_q;
  assign ex_alu_op_o    = ex_alu_op_q;
  assign ex_waddr_o     = ex_waddr_q;
  assign ex_raddr1_o    = ex_raddr1_q;
  assign ex_raddr2_o    = ex_raddr2_q;
  assign ex_imm_o       = ex_imm_q;
  assign stall_count_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each directed cycle pushes its expected EX state,
// stall and stall count; a monitor pops and compares late in the same cycle.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, id_valid_i, id_uses_r2_i;
  logic [3:0]  id_raddr1_i, id_raddr2_i, id_waddr_i, id_alu_op_i;
  logic [15:0] id_rdata1_i, id_rdata2_i, id_imm_i;
  logic        id_mem_read_i, id_mem_write_i, id_reg_write_i;
  logic [3:0]  mem_waddr_i;
  logic        mem_reg_write_i;
  logic [15:0] mem_result_i;
  logic        stall_o, ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o;
  logic [3:0]  ex_alu_op_o, ex_waddr_o, ex_raddr1_o, ex_raddr2_o;
  logic [15:0] ex_op_a_o, ex_op_b_o, ex_imm_o, stall_count_o;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i), .id_waddr_i(id_waddr_i),
    .id_uses_r2_i(id_uses_r2_i), .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i),
    .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_reg_write_i(id_reg_write_i),
    .mem_waddr_i(mem_waddr_i), .mem_reg_write_i(mem_reg_write_i), .mem_result_i(mem_result_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_waddr_o(ex_waddr_o), .ex_raddr1_o(ex_raddr1_o),
    .ex_raddr2_o(ex_raddr2_o), .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o),
    .ex_imm_o(ex_imm_o), .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          tag;
    logic        stall, valid, mr, rw, chk;
    logic [3:0]  waddr, alu, ra1;
    logic [15:0] cnt, opa, opb, imm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] pre_cnt;
  logic        pre_stall;

  task automatic cmp(input string name, input int tag, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, tag, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #8;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("stall", e.tag, {15'd0, stall_o}, {15'd0, e.stall});
        cmp("ex_valid", e.tag, {15'd0, ex_valid_o}, {15'd0, e.valid});
        cmp("ex_waddr", e.tag, {12'd0, ex_waddr_o}, {12'd0, e.waddr});
        cmp("ex_memread", e.tag, {15'd0, ex_mem_read_o}, {15'd0, e.mr});
        cmp("ex_regwrite", e.tag, {15'd0, ex_reg_write_o}, {15'd0, e.rw});
        cmp("ex_memwrite", e.tag, {15'd0, ex_mem_write_o}, 16'd0);
        cmp("stall_count", e.tag, stall_count_o, e.cnt);
        if (e.chk) begin
          cmp("ex_opa", e.tag, ex_op_a_o, e.opa);
          cmp("ex_opb", e.tag, ex_op_b_o, e.opb);
          cmp("ex_imm", e.tag, ex_imm_o, e.imm);
          cmp("ex_aluop", e.tag, {12'd0, ex_alu_op_o}, {12'd0, e.alu});
          cmp("ex_raddr1", e.tag, {12'd0, ex_raddr1_o}, {12'd0, e.ra1});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                          input logic ur2, input logic [3:0] wa, input logic [15:0] rd1,
                          input logic [15:0] rd2, input logic [15:0] imm, input logic [3:0] alu,
                          input logic mr, input logic mw, input logic rw);
    id_valid_i = v;     id_raddr1_i = ra1;  id_raddr2_i = ra2; id_uses_r2_i = ur2;
    id_waddr_i = wa;    id_rdata1_i = rd1;  id_rdata2_i = rd2; id_imm_i = imm;
    id_alu_op_i = alu;  id_mem_read_i = mr; id_mem_write_i = mw; id_reg_write_i = rw;
  endtask

  task automatic drive_mem(input logic [3:0] wa, input logic rw, input logic [15:0] res);
    mem_waddr_i = wa; mem_reg_write_i = rw; mem_result_i = res;
  endtask

  task automatic expect_row(input int tag, input logic stall, input logic valid,
                            input logic [3:0] waddr, input logic mr, input logic rw,
                            input logic [15:0] cnt, input logic chk, input logic [15:0] opa,
                            input logic [15:0] opb, input logic [15:0] imm,
                            input logic [3:0] alu, input logic [3:0] ra1);
    exp_t e;
    e.tag = tag; e.stall = stall; e.valid = valid; e.waddr = waddr; e.mr = mr; e.rw = rw;
    e.cnt = cnt; e.chk = chk; e.opa = opa; e.opb = opb; e.imm = imm; e.alu = alu; e.ra1 = ra1;
    sb_q.push_back(e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_mem(0, 0, 0);
    next_cycle();
    next_cycle();
    expect_row(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // add R3 <- R1 + R2 ; EX still empty right after reset
    next_cycle(); rst_i = 1'b0;
    drive_id(1, 1, 2, 1, 3, 16'd5, 16'd7, 16'h0011, 2, 0, 0, 1);
    expect_row(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // load R4
    next_cycle(); drive_id(1, 1, 0, 0, 4, 16'd5, 16'd0, 16'd8, 0, 1, 0, 1);
    expect_row(3, 0, 1, 3, 0, 1, 0, 1, 16'd5, 16'd7, 16'h0011, 2, 1);
    // add R6 <- R4 + R2 : load-use
    next_cycle(); drive_id(1, 4, 2, 1, 6, 16'h0100, 16'd7, 16'd0, 2, 0, 0, 1);
    expect_row(4, 1, 1, 4, 1, 1, 0, 1, 16'd5, 16'd0, 16'd8, 0, 1);
    next_cycle();
    expect_row(5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_row(6, 0, 1, 6, 0, 1, 1, 1, 16'h0100, 16'd7, 16'd0, 2, 4);
    // load R4, then consumer with flush
    next_cycle(); drive_id(1, 1, 0, 0, 4, 16'd9, 16'd0, 16'd2, 0, 1, 0, 1);
    expect_row(7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); flush_i = 1'b1; drive_id(1, 4, 0, 0, 7, 16'h0055, 16'd0, 16'd0, 1, 0, 0, 1);
    expect_row(8, 0, 1, 4, 1, 1, 1, 1, 16'd9, 16'd0, 16'd2, 0, 1);
    // load R0, then reader of R0
    next_cycle(); flush_i = 1'b0; drive_id(1, 1, 0, 0, 0, 16'd3, 16'd0, 16'd4, 0, 1, 0, 1);
    expect_row(9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(1, 0, 0, 1, 8, 16'd0, 16'd0, 16'd0, 2, 0, 0, 1);
    expect_row(10, 0, 1, 0, 1, 1, 1, 1, 16'd3, 16'd0, 16'd4, 0, 1);
    // load R4, then reader with R2=R4 but UsesR2=0
    next_cycle(); drive_id(1, 1, 0, 0, 4, 16'h0020, 16'd0, 16'd6, 0, 1, 0, 1);
    expect_row(11, 0, 1, 8, 0, 1, 1, 1, 16'd0, 16'd0, 16'd0, 2, 0);
    next_cycle(); drive_id(1, 1, 4, 0, 9, 16'h0030, 16'h0040, 16'd0, 2, 0, 0, 1);
    expect_row(12, 0, 1, 4, 1, 1, 1, 1, 16'h0020, 16'd0, 16'd6, 0, 1);
    // load R4, then an invalid ID slot that names R4
    next_cycle(); drive_id(1, 2, 0, 0, 4, 16'h0021, 16'd0, 16'd1, 0, 1, 0, 1);
    expect_row(13, 0, 1, 9, 0, 1, 1, 1, 16'h0030, 16'h0040, 16'd0, 2, 1);
    next_cycle(); drive_id(0, 4, 4, 1, 10, 16'd0, 16'd0, 16'd0, 2, 0, 0, 1);
    expect_row(14, 0, 1, 4, 1, 1, 1, 1, 16'h0021, 16'd0, 16'd1, 0, 2);
    // load R4, then reader through R2 with UsesR2=1
    next_cycle(); drive_id(1, 2, 0, 0, 4, 16'h0044, 16'd0, 16'd3, 0, 1, 0, 1);
    expect_row(15, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(1, 1, 4, 1, 10, 16'h0011, 16'h0099, 16'd0, 2, 0, 0, 1);
    expect_row(16, 1, 1, 4, 1, 1, 1, 1, 16'h0044, 16'd0, 16'd3, 0, 2);
    next_cycle();
    expect_row(17, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_row(18, 0, 1, 10, 0, 1, 2, 1, 16'h0011, 16'h0099, 16'd0, 2, 1);
    // add R5, then non-load reader of R5
    next_cycle(); drive_id(1, 1, 2, 1, 5, 16'd1, 16'd2, 16'd0, 2, 0, 0, 1);
    expect_row(19, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(1, 5, 0, 0, 11, 16'h005A, 16'd0, 16'd0, 2, 0, 0, 1);
`ifdef FWD_EN
    expect_row(20, 0, 1, 5, 0, 1, 2, 1, 16'd1, 16'd2, 16'd0, 2, 1);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); drive_mem(5, 1, 16'h0077);
    expect_row(21, 0, 1, 11, 0, 1, 2, 1, 16'h0077, 16'd0, 16'd0, 2, 5);
    next_cycle(); drive_mem(0, 0, 0);
    expect_row(22, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
`else
    expect_row(20, 1, 1, 5, 0, 1, 2, 1, 16'd1, 16'd2, 16'd0, 2, 1);
    next_cycle(); drive_mem(5, 1, 16'h0077);
    expect_row(21, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_mem(0, 0, 0);
    expect_row(22, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_row(23, 0, 1, 11, 0, 1, 4, 1, 16'h005A, 16'd0, 16'd0, 2, 5);
`endif
    pre_cnt = stall_count_o;
    // EX reader of R3 while EX/MEM writes R3, then with MEM_WAddr=0
    next_cycle(); drive_id(1, 3, 0, 0, 12, 16'h0022, 16'd0, 16'd0, 2, 0, 0, 1);
`ifdef FWD_EN
    pre_cnt = 16'd2;
`else
    pre_cnt = 16'd4;
`endif
    expect_row(30, 0, 0, 0, 0, 0, pre_cnt, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); drive_mem(3, 1, 16'h00AA);
`ifdef FWD_EN
    expect_row(31, 0, 1, 12, 0, 1, pre_cnt, 1, 16'h00AA, 16'd0, 16'd0, 2, 3);
`else
    expect_row(31, 0, 1, 12, 0, 1, pre_cnt, 1, 16'h0022, 16'd0, 16'd0, 2, 3);
`endif
    next_cycle(); drive_id(1, 3, 0, 0, 13, 16'h0033, 16'd0, 16'd0, 2, 0, 0, 1); drive_mem(0, 0, 0);
    expect_row(32, 0, 0, 0, 0, 0, pre_cnt, 0, 0, 0, 0, 0, 0);
    next_cycle(); drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); drive_mem(0, 1, 16'h00AA);
    expect_row(33, 0, 1, 13, 0, 1, pre_cnt, 1, 16'h0033, 16'd0, 16'd0, 2, 3);
`ifdef FWD_EN
    pre_stall = 1'b0;
    next_cycle(); drive_mem(0, 0, 0);
`else
    // Reader of R5 held against a permanent EX/MEM producer: stall every cycle
    pre_stall = 1'b1;
    next_cycle(); drive_id(1, 5, 0, 0, 14, 16'd0, 16'd0, 16'd0, 2, 0, 0, 1); drive_mem(5, 1, 16'd0);
    expect_row(40, 1, 0, 0, 0, 0, 16'd4, 0, 0, 0, 0, 0, 0);
    repeat (65529) next_cycle();
    next_cycle();
    expect_row(41, 1, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 0, 0, 0);
    next_cycle();
    expect_row(42, 1, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    repeat (5) next_cycle();
    next_cycle();
    expect_row(43, 1, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    pre_cnt = 16'hFFFF;
`endif
    // Reset, mid-stall in the default build
    next_cycle(); rst_i = 1'b1;
    expect_row(44, pre_stall, 0, 0, 0, 0, pre_cnt, 0, 0, 0, 0, 0, 0);
    next_cycle(); rst_i = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); drive_mem(0, 0, 0);
    expect_row(45, 0, 0, 0, 0, 0, 16'd0, 1, 0, 0, 0, 0, 0);
    next_cycle();
    expect_row(46, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk_i);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
